// File: rtl/mem_access_arbiter.sv
// Two-requester (read/write) front end onto a single-outstanding memory port.
// Round-robin grant, width/alignment screening, lane placement of write data,
// read data extraction, and a bounded wait for the memory response.
module mem_access_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rd_req_valid,
  output logic        rd_req_ready,
  input  logic [63:0] rd_req_addr,
  input  logic [2:0]  rd_req_memWidth,
  output logic        rd_resp_valid,
  output logic [63:0] rd_resp_data,
  output logic        rd_resp_err,
  input  logic        wr_req_valid,
  output logic        wr_req_ready,
  input  logic [63:0] wr_req_addr,
  input  logic [63:0] wr_req_data,
  input  logic [2:0]  wr_req_memWidth,
  output logic        wr_resp_valid,
  output logic        wr_resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wen,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [63:0] addr_q, data_q;
  logic [2:0]  width_q;
  logic        is_wr_q;
  logic        last_wr_q;
  logic [7:0]  cnt_q;

  logic        accept;
  logic [63:0] sel_addr;
  logic [2:0]  sel_width;
  logic        done_ok, done_fail, issuing;

  // Byte-lane enables for an access of 2^width bytes starting at offset.
  function automatic logic [7:0] lane_mask(input logic [2:0] width, input logic [2:0] offset);
    logic [7:0] base;
    case (width)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

  // Move the addressed bytes down to bit 0 and zero everything above the access width.
  function automatic logic [63:0] read_align(input logic [63:0] raw, input logic [2:0] width,
                                             input logic [2:0] offset);
    logic [63:0] shifted;
    logic [63:0] result;
    shifted = raw >> {offset, 3'b000};
    case (width)
      3'd0:    result = {56'd0, shifted[7:0]};
      3'd1:    result = {48'd0, shifted[15:0]};
      3'd2:    result = {32'd0, shifted[31:0]};
      default: result = shifted;
    endcase
    return result;
  endfunction

  // Width codes 4..7 are illegal; otherwise the offset must be a multiple of the access size.
  function automatic logic bad_request(input logic [2:0] width, input logic [2:0] offset);
    logic [2:0] low;
    case (width)
      3'd0:    low = 3'b000;
      3'd1:    low = 3'b001;
      3'd2:    low = 3'b011;
      default: low = 3'b111;
    endcase
    return width[2] || ((offset & low) != 3'b000);
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant, next-state and completion decode.
  always_comb begin
    state_nxt    = state;
    rd_req_ready = 1'b0;
    wr_req_ready = 1'b0;
    done_ok      = 1'b0;
    done_fail    = 1'b0;
    case (state)
      IDLE: begin
        // On conflict the read wins only if the previous grant went to the write side.
        if (rd_req_valid && (!wr_req_valid || last_wr_q)) rd_req_ready = 1'b1;
        else if (wr_req_valid)                            wr_req_ready = 1'b1;
        if (rd_req_ready || wr_req_ready)
          state_nxt = bad_request(sel_width, sel_addr[2:0]) ? ERR : ISSUE;
      end
      ISSUE: if (mem_ready) state_nxt = WAIT;
      WAIT: begin
        if (mem_rvalid) begin
          done_ok   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_q == TO_LAST) begin
          done_fail = 1'b1;
          state_nxt = IDLE;
        end
      end
      ERR: begin
        done_fail = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = rd_req_ready || wr_req_ready;
  assign sel_addr  = wr_req_ready ? wr_req_addr : rd_req_addr;
  assign sel_width = wr_req_ready ? wr_req_memWidth : rd_req_memWidth;

  // Request capture, wait counter, grant history and registered responses.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q  <= sel_addr;
      data_q  <= wr_req_data;
      width_q <= sel_width;
      is_wr_q <= wr_req_ready;
    end
    if (reset) begin
      last_wr_q     <= 1'b1;
      cnt_q         <= 8'd0;
      rd_resp_valid <= 1'b0;
      rd_resp_data  <= 64'd0;
      rd_resp_err   <= 1'b0;
      wr_resp_valid <= 1'b0;
      wr_resp_err   <= 1'b0;
    end else begin
      rd_resp_valid <= 1'b0;
      wr_resp_valid <= 1'b0;
      if (accept) last_wr_q <= wr_req_ready;
      if (state == WAIT && !mem_rvalid) cnt_q <= cnt_q + 8'd1;
      else                              cnt_q <= 8'd0;
      if (done_ok || done_fail) begin
        if (is_wr_q) begin
          wr_resp_valid <= 1'b1;
          wr_resp_err   <= done_fail;
        end else begin
          rd_resp_valid <= 1'b1;
          rd_resp_err   <= done_fail;
          rd_resp_data  <= done_ok ? read_align(mem_rdata, width_q, addr_q[2:0]) : 64'd0;
        end
      end
    end
  end

  // Memory request outputs are only non-zero while the request is being presented.
  assign issuing   = (state == ISSUE);
  assign mem_valid = issuing;
  assign mem_wen   = issuing && is_wr_q;
  assign mem_addr  = issuing ? {addr_q[63:3], 3'b000} : 64'd0;
  assign mem_wdata = (issuing && is_wr_q) ? (data_q << {addr_q[2:0], 3'b000}) : 64'd0;
  assign mem_wmask = (issuing && is_wr_q) ? lane_mask(width_q, addr_q[2:0]) : 8'd0;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized bench for mem_access_arbiter. The reference is a transaction
// timeline: at each grant the bench plans memory-side delays and derives, with
// plain arithmetic, the cycles on which mem_valid and the response must appear.
module tb_mem_access_arbiter;
  localparam int TO = 4;
  localparam int NCYC = 4000;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd_req_valid, rd_req_ready;
  logic [63:0] rd_req_addr;
  logic [2:0]  rd_req_memWidth;
  logic        rd_resp_valid, rd_resp_err;
  logic [63:0] rd_resp_data;
  logic        wr_req_valid, wr_req_ready;
  logic [63:0] wr_req_addr, wr_req_data;
  logic [2:0]  wr_req_memWidth;
  logic        wr_resp_valid, wr_resp_err;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  mem_access_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_memWidth(rd_req_memWidth),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_req_memWidth(wr_req_memWidth),
    .wr_resp_valid(wr_resp_valid), .wr_resp_err(wr_resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Mostly legal widths, sometimes an illegal code.
  function automatic logic [2:0] pick_width();
    int r;
    r = $urandom_range(0, 15);
    if (r < 13) return 3'(r % 4);
    return 3'(4 + (r % 4));
  endfunction

  // Random address, aligned to the access size most of the time.
  function automatic logic [63:0] pick_addr(input logic [2:0] w);
    logic [63:0] a;
    int size;
    a = rand64();
    if (w < 3'd4 && $urandom_range(0, 99) < 70) begin
      size = 1 << int'(w);
      a[2:0] = 3'((int'(a[2:0]) / size) * size);
    end
    return a;
  endfunction

  // Reference-model state: one planned transaction plus arbitration history.
  bit          t_valid, t_wr, t_bad, t_to, last_wr;
  int          t_n, t_d, t_r, t_resp, free_at;
  logic [63:0] t_addr, t_data, t_rdata;
  int          t_w;

  initial begin
    bit          rst_now, idle, in_issue, in_wait, exp_rd_g, exp_wr_g, exp_resp;
    int          ws, off, bytes;
    logic [63:0] e_addr, e_wdata, rmask;
    logic [15:0] m16;
    logic [7:0]  e_mask;

    reset = 1'b1;
    rd_req_valid = 0; rd_req_addr = 0; rd_req_memWidth = 0;
    wr_req_valid = 0; wr_req_addr = 0; wr_req_data = 0; wr_req_memWidth = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(negedge clock);
    t_valid = 0; last_wr = 1; free_at = 0; t_rdata = 0;

    while (cyc < NCYC) begin
      // Requesters.
      rst_now = (cyc > 0) && ($urandom_range(0, 249) == 0);
      reset = rst_now;
      rd_req_valid    = (cyc > 0) && !rst_now && ($urandom_range(0, 99) < 55);
      wr_req_valid    = (cyc > 0) && !rst_now && ($urandom_range(0, 99) < 55);
      rd_req_memWidth = pick_width();
      rd_req_addr     = pick_addr(rd_req_memWidth);
      wr_req_memWidth = pick_width();
      wr_req_addr     = pick_addr(wr_req_memWidth);
      wr_req_data     = rand64();
      mem_rdata       = rand64();

      // Memory side: follow the plan inside the transaction windows, noise elsewhere.
      ws = t_n + 2 + t_d;
      in_issue = t_valid && !t_bad && cyc >= t_n + 1 && cyc <= t_n + 1 + t_d;
      in_wait  = t_valid && !t_bad && cyc >= ws && cyc < ws + TO && (t_to || cyc <= ws + t_r);
      mem_ready  = in_issue ? (cyc == t_n + 1 + t_d) : ($urandom_range(0, 1) == 1);
      mem_rvalid = in_wait ? (!t_to && cyc == ws + t_r) : ($urandom_range(0, 1) == 1);
      if (in_wait && !t_to && cyc == ws + t_r) begin
        off   = int'(t_addr[2:0]);
        bytes = 1 << t_w;
        rmask = (bytes == 8) ? '1 : ((64'd1 << (8 * bytes)) - 64'd1);
        t_rdata = (mem_rdata >> (8 * off)) & rmask;
      end
      #1;

      // Expected grant.
      idle = (cyc >= free_at);
      exp_rd_g = 0; exp_wr_g = 0;
      if (idle) begin
        if (rd_req_valid && wr_req_valid) begin
          if (last_wr) exp_rd_g = 1; else exp_wr_g = 1;
        end else if (rd_req_valid) exp_rd_g = 1;
        else if (wr_req_valid) exp_wr_g = 1;
      end
      check_eq("rd_req_ready", 64'(rd_req_ready), 64'(exp_rd_g));
      check_eq("wr_req_ready", 64'(wr_req_ready), 64'(exp_wr_g));

      // Expected memory request.
      off    = int'(t_addr[2:0]);
      bytes  = 1 << (t_w & 3);
      m16    = ((16'd1 << bytes) - 16'd1) << off;
      e_mask = (in_issue && t_wr) ? m16[7:0] : 8'd0;
      e_addr = in_issue ? {t_addr[63:3], 3'b000} : 64'd0;
      e_wdata = (in_issue && t_wr) ? (t_data << (8 * off)) : 64'd0;
      check_eq("mem_valid", 64'(mem_valid), 64'(in_issue));
      check_eq("mem_wen",   64'(mem_wen),   64'(in_issue && t_wr));
      check_eq("mem_addr",  mem_addr, e_addr);
      check_eq("mem_wdata", mem_wdata, e_wdata);
      check_eq("mem_wmask", 64'(mem_wmask), 64'(e_mask));

      // Expected responses.
      exp_resp = t_valid && (cyc == t_resp);
      check_eq("rd_resp_valid", 64'(rd_resp_valid), 64'(exp_resp && !t_wr));
      check_eq("wr_resp_valid", 64'(wr_resp_valid), 64'(exp_resp && t_wr));
      if (exp_resp && !t_wr) begin
        check_eq("rd_resp_err",  64'(rd_resp_err), 64'(t_bad || t_to));
        check_eq("rd_resp_data", rd_resp_data, (t_bad || t_to) ? 64'd0 : t_rdata);
      end
      if (exp_resp && t_wr)
        check_eq("wr_resp_err", 64'(wr_resp_err), 64'(t_bad || t_to));

      // Advance the model across the coming edge.
      if (rst_now) begin
        t_valid = 0;
        free_at = cyc + 1;
        last_wr = 1;
      end else if (exp_rd_g || exp_wr_g) begin
        t_valid = 1;
        t_wr    = exp_wr_g;
        t_addr  = t_wr ? wr_req_addr : rd_req_addr;
        t_w     = int'(t_wr ? wr_req_memWidth : rd_req_memWidth);
        t_data  = wr_req_data;
        t_bad   = (t_w > 3) || ((int'(t_addr[2:0]) % (1 << (t_w & 3))) != 0);
        t_n     = cyc;
        t_d     = $urandom_range(0, 3);
        t_r     = $urandom_range(0, TO + 1);
        t_to    = (t_r >= TO);
        if (t_bad)     t_resp = cyc + 2;
        else if (t_to) t_resp = cyc + 2 + t_d + TO;
        else           t_resp = cyc + 3 + t_d + t_r;
        free_at = t_resp;
        last_wr = exp_wr_g;
      end

      @(negedge clock);
      cyc++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
